// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Holds the datapath width, the default access timeout, the byte-enable width,
// the MEM access FSM state encodings and a small lane-to-enable helper.
package memory_stage_pkg;

  localparam int WORD_SIZE       = 32;
  localparam int DEFAULT_TIMEOUT = 16;
  localparam int BE_WIDTH        = WORD_SIZE / 8;

  // MEM_IDLE: no access outstanding; MEM_WAIT: request issued, waiting on mem_ready
  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  // One-hot byte enable for the byte lane addressed by the two low address bits
  function automatic logic [BE_WIDTH-1:0] lane_onehot(input logic [1:0] lane);
    logic [BE_WIDTH-1:0] one;
    one = {{(BE_WIDTH-1){1'b0}}, 1'b1};
    return one << lane;
  endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// Byte-lane handling for the MEM stage, purely combinational.
// Ports:
//   byte_access  in   1 = byte access, 0 = word access
//   lane         in   byte lane (low two address bits)
//   rdata        in   word returned by memory
//   wdata        in   store data from the M register
//   load_data    out  zero-extended selected byte, or the whole word
//   store_data   out  byte replicated to all lanes, or the whole word
//   be           out  byte enables (one-hot lane or all ones)
module load_align
  import memory_stage_pkg::*;
(
  input  logic                 byte_access,
  input  logic [1:0]           lane,
  input  logic [WORD_SIZE-1:0] rdata,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] load_data,
  output logic [WORD_SIZE-1:0] store_data,
  output logic [BE_WIDTH-1:0]  be
);

  // Word accesses pass straight through with all lanes enabled; byte accesses
  // pick one lane on loads and fan the low byte out to every lane on stores so
  // that the byte enable alone decides which lane the memory writes.
  always_comb begin
    load_data  = rdata;
    store_data = wdata;
    be         = '1;
    if (byte_access) begin
      load_data  = {{(WORD_SIZE-8){1'b0}}, rdata[{lane, 3'b000} +: 8]};
      store_data = {BE_WIDTH{wdata[7:0]}};
      be         = lane_onehot(lane);
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: performs loads/stores against a multi-cycle data memory
// through a req/ready handshake, stalls the execute stage while an access is
// outstanding, and registers results into the W pipeline register.
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   ALUResultM/WriteDataM/PCPlus4M M-side datapath inputs
//   RdM, RegWriteM, MemWriteM, ReadEnableM, ByteAddressM, ResultSrcM  M control
//   mem_ready, mem_rdata           memory completion and read word
//   mem_req, mem_we, mem_addr, mem_wdata, mem_be   memory request side
//   StallM                         holds execute stage and M register
//   MemError                       sticky access-timeout flag
//   ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW  W register
//   RdMH, RegWriteMH               hazard unit copies of RdM / RegWriteM
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] ALUResultM,
  input  logic [WORD_SIZE-1:0] WriteDataM,
  input  logic [WORD_SIZE-1:0] PCPlus4M,
  input  logic [4:0]           RdM,
  input  logic                 RegWriteM,
  input  logic                 MemWriteM,
  input  logic                 ReadEnableM,
  input  logic                 ByteAddressM,
  input  logic [1:0]           ResultSrcM,
  input  logic                 mem_ready,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic [BE_WIDTH-1:0]  mem_be,
  output logic                 StallM,
  output logic                 MemError,
  output logic [WORD_SIZE-1:0] ALUResultW,
  output logic [WORD_SIZE-1:0] ReadDataW,
  output logic [WORD_SIZE-1:0] PCPlus4W,
  output logic [4:0]           RdW,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcW,
  output logic [4:0]           RdMH,
  output logic                 RegWriteMH
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  mem_state_t             state;
  mem_state_t             state_next;
  logic [CNT_W-1:0]       wait_cnt;
  logic                   access;
  logic                   timeout_hit;
  logic                   timed_out;
  logic [WORD_SIZE-1:0]   load_data;
  logic [WORD_SIZE-1:0]   read_data_next;

  assign access      = ReadEnableM | MemWriteM;
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  assign RdMH       = RdM;
  assign RegWriteMH = RegWriteM;

  // Address, data and enables come straight from the held M register, so they
  // stay stable for the whole access without extra capture flops.
  assign mem_addr = {ALUResultM[WORD_SIZE-1:2], 2'b00};
  assign mem_we   = mem_req & MemWriteM;

  load_align u_load_align (
    .byte_access (ByteAddressM),
    .lane        (ALUResultM[1:0]),
    .rdata       (mem_rdata),
    .wdata       (WriteDataM),
    .load_data   (load_data),
    .store_data  (mem_wdata),
    .be          (mem_be)
  );

  // Next-state and handshake outputs. Reset forces the request and stall low
  // immediately so a dropped transaction never reaches the memory again.
  always_comb begin
    state_next     = state;
    mem_req        = 1'b0;
    StallM         = 1'b0;
    timed_out      = 1'b0;
    read_data_next = '0;
    if (!rst) begin
      unique case (state)
        MEM_IDLE: begin
          if (access) begin
            mem_req    = 1'b1;
            StallM     = 1'b1;
            state_next = MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            state_next = MEM_IDLE;
            if (!MemWriteM) begin
              read_data_next = load_data;
            end
          end else if (timeout_hit) begin
            timed_out  = 1'b1;
            state_next = MEM_IDLE;
          end else begin
            StallM = 1'b1;
          end
        end
        default: state_next = MEM_IDLE;
      endcase
    end
  end

  // State, timeout counter and sticky error. The counter only runs while the
  // FSM stays in WAIT, so it is zero on every fresh access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MEM_IDLE;
      wait_cnt <= '0;
      MemError <= 1'b0;
    end else begin
      state <= state_next;
      if (state == MEM_WAIT && state_next == MEM_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (timed_out) begin
        MemError <= 1'b1;
      end
    end
  end

  // W pipeline register: a bubble while stalled so an instruction is written
  // back exactly once, on the cycle its result is final.
  always_ff @(posedge clk) begin
    if (rst || StallM) begin
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
    end else begin
      ALUResultW <= ALUResultM;
      ReadDataW  <= read_data_next;
      PCPlus4W   <= PCPlus4M;
      RdW        <= RdM;
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
    end
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline MEM stage, directly downstream of the execute stage.
- Consumes the M-side pipeline register outputs: ALU result, store data, Rd, control bits.
- Performs loads and stores against a multi-cycle data memory through a req/ready handshake, and holds the execute stage via StallM while an access is outstanding.
- Registers results into the W-side pipeline register for writeback.

Parameters:
- WORD_SIZE, `WORD_SIZE (32), datapath width; taken from constants.v.
- TIMEOUT, 16, maximum cycles in WAIT before an access is abandoned.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- ALUResultM  in  WORD_SIZE  effective address / ALU result
- WriteDataM  in  WORD_SIZE  store data
- PCPlus4M  in  WORD_SIZE  PC+4 for jump link
- RdM  in  5  destination register
- RegWriteM, MemWriteM, ReadEnableM, ByteAddressM  in  1 each  control (ByteAddressM=1: byte access)
- ResultSrcM  in  2  writeback select, passed through
- mem_ready  in  1  memory completion
- mem_rdata  in  WORD_SIZE  memory read word
- mem_req  out  1  access request
- mem_we  out  1  write request
- mem_addr  out  WORD_SIZE  word-aligned address (ALUResultM with [1:0]=0)
- mem_wdata  out  WORD_SIZE  store data; byte store replicates WriteDataM[7:0] into all four lanes
- mem_be  out  4  byte enables
- StallM  out  1  hold the execute stage and the M register
- MemError  out  1  sticky timeout flag
- ALUResultW, ReadDataW, PCPlus4W  out  WORD_SIZE  W pipeline register
- RdW  out  5  W pipeline register
- RegWriteW  out  1  W pipeline register
- ResultSrcW  out  2  W pipeline register
- RdMH  out  5  hazard unit copy of RdM
- RegWriteMH  out  1  hazard unit copy of RegWriteM

Behaviour:
- Clock and reset: single clock clk; synchronous, active-high rst.
- Reset values: all W registers 0, state IDLE, timeout counter 0, MemError 0. While rst is high, mem_req and StallM are 0.
- access = ReadEnableM | MemWriteM. If both are set, the access is treated as a write.
- FSM states:
  - IDLE: if access, drive mem_req=1 and StallM=1, then go to WAIT. Otherwise StallM=0 and the W registers load the M inputs (non-memory instruction, 1-cycle latency).
  - WAIT: mem_req=1 held, with address, data and be stable. The counter increments each cycle.
    - If mem_ready: StallM=0 and the W registers load, with ReadDataW from the byte/word selection below; go to IDLE, counter cleared.
    - Else if counter == TIMEOUT-1: set MemError, StallM=0, W loads with ReadDataW=0, go to IDLE.
- mem_ready is sampled only in WAIT. Minimum memory access is 2 cycles (issue + 1); mem_ready asserted in IDLE is ignored.
- Bubbles: while StallM=1, the W registers load a bubble (RegWriteW=0, RdW=0) so no writeback is duplicated.
- Byte access:
  - Loads zero-extend mem_rdata lane ALUResultM[1:0].
  - Stores set mem_be = one-hot(ALUResultM[1:0]).
- Word access: mem_be=4'b1111. Bits ALUResultM[1:0] are ignored.
- mem_we = MemWriteM while mem_req is asserted, else 0.
- For a write, ReadDataW is 0.
- MemError is cleared only by rst.
- Reset mid-access (rst in WAIT): next state IDLE, mem_req=0 from that edge onward. The pending transaction is dropped with no W update.
- RdMH and RegWriteMH are combinational copies of RdM and RegWriteM.

Decomposition:
- constants.v: add the FSM state encodings MEM_IDLE and MEM_WAIT, and the byte-enable width.
- One sub-module, load_align: combinational lane select and zero-extend for loads, plus store replication and be generation.

Test Plan:
- ALU op, RegWriteM=1, RdM=5, ALUResultM=0x1234 -> next cycle RdW=5, ALUResultW=0x1234, StallM never asserted.
- Word load at addr 0x100, mem_ready after 3 WAIT cycles with mem_rdata=0xDEADBEEF -> StallM high 4 cycles, one W load with ReadDataW=0xDEADBEEF and RegWriteW=1 exactly once, RegWriteW=0 in all stalled cycles.
- Byte load at 0x102, mem_rdata=0xAABBCCDD -> ReadDataW=0x000000BB.
- Byte store at 0x103, WriteDataM=0x7F -> mem_be=4'b1000, mem_wdata=0x7F7F7F7F, mem_we=1 until mem_ready.
- Load with mem_ready never asserted -> after 16 WAIT cycles MemError=1, StallM=0, ReadDataW=0; the next ALU instruction proceeds normally.
- rst pulsed during WAIT -> next cycle mem_req=0, StallM=0, all W outputs 0, MemError=0.
